// File: rtl/tpu_seq.sv
// Run sequencer for the TPU datapath: loads weights, streams activations and writes
// results through the single scratchpad port, which the host owns while idle.
module tpu_seq #(
    parameter int DIM        = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int CNT_WIDTH  = 16,
    localparam int RW        = (DIM > 1) ? $clog2(DIM) : 1
) (
    input  logic                  s_axi_aclk,
    input  logic                  s_axi_aresetn,
    input  logic                  cfg_start,
    input  logic                  cfg_done_clr,
    input  logic [ADDR_WIDTH-1:0] cfg_w_base,
    input  logic [ADDR_WIDTH-1:0] cfg_a_base,
    input  logic [ADDR_WIDTH-1:0] cfg_o_base,
    input  logic [CNT_WIDTH-1:0]  cfg_rows,
    output logic                  sts_busy,
    output logic                  sts_done,
    output logic                  sts_err,
    output logic [CNT_WIDTH-1:0]  sts_cycles,
    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic                  host_gnt,
    output logic [DATA_WIDTH-1:0] host_rdata,
    output logic                  host_rvalid,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  arr_w_load,
    output logic [RW-1:0]         arr_w_row,
    output logic [DATA_WIDTH-1:0] arr_w_data,
    output logic                  arr_a_valid,
    output logic [DATA_WIDTH-1:0] arr_a_data,
    input  logic                  arr_r_valid,
    input  logic [DATA_WIDTH-1:0] arr_r_data
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD_W = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;
    localparam logic [1:0] ST_DRAIN  = 2'd3;

    // Wide enough that base + count never wraps before the range comparison.
    localparam int EW = ((ADDR_WIDTH > CNT_WIDTH) ? ADDR_WIDTH : CNT_WIDTH) + 2;

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] w_base_q, w_base_d;
    logic [ADDR_WIDTH-1:0] a_base_q, a_base_d;
    logic [ADDR_WIDTH-1:0] o_base_q, o_base_d;
    logic [CNT_WIDTH-1:0]  rows_q, rows_d;
    logic [CNT_WIDTH-1:0]  act_cnt_q, act_cnt_d;
    logic [CNT_WIDTH-1:0]  res_cnt_q, res_cnt_d;
    logic [CNT_WIDTH-1:0]  cycles_q, cycles_d;
    logic [RW-1:0]         w_cnt_q, w_cnt_d;
    logic [RW-1:0]         w_row_q, w_row_d;
    logic                  w_load_q, w_load_d;
    logic                  a_valid_q, a_valid_d;
    logic                  rvalid_q, rvalid_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic [EW-1:0] a_end, o_end, w_end, addr_lim;
    logic          cfg_bad;
    logic          idle;

    assign idle     = (state_q == ST_IDLE);
    assign a_end    = EW'(cfg_a_base) + EW'(cfg_rows);
    assign o_end    = EW'(cfg_o_base) + EW'(cfg_rows);
    assign w_end    = EW'(cfg_w_base) + EW'(DIM);
    assign addr_lim = EW'(1) << ADDR_WIDTH;
    assign cfg_bad  = (cfg_rows == '0) || (a_end > addr_lim) ||
                      (o_end > addr_lim) || (w_end > addr_lim);

    always_comb begin
        state_d   = state_q;
        w_base_d  = w_base_q;
        a_base_d  = a_base_q;
        o_base_d  = o_base_q;
        rows_d    = rows_q;
        act_cnt_d = act_cnt_q;
        res_cnt_d = res_cnt_q;
        cycles_d  = cycles_q;
        w_cnt_d   = w_cnt_q;
        w_row_d   = w_row_q;
        w_load_d  = 1'b0;
        a_valid_d = 1'b0;
        rvalid_d  = 1'b0;
        done_d    = done_q;
        err_d     = err_q;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        // Clear first so that any set below in the same cycle takes precedence.
        if (cfg_done_clr) begin
            done_d = 1'b0;
            err_d  = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                mem_en    = host_req;
                mem_we    = host_req && host_we;
                mem_addr  = host_addr;
                mem_wdata = host_wdata;
                rvalid_d  = host_req && !host_we;
                if (cfg_start) begin
                    w_base_d  = cfg_w_base;
                    a_base_d  = cfg_a_base;
                    o_base_d  = cfg_o_base;
                    rows_d    = cfg_rows;
                    w_cnt_d   = '0;
                    act_cnt_d = '0;
                    res_cnt_d = '0;
                    cycles_d  = '0;
                    done_d    = 1'b0;
                    err_d     = cfg_bad;
                    if (!cfg_bad) begin
                        state_d = ST_LOAD_W;
                    end
                end
            end

            ST_LOAD_W: begin
                mem_en   = 1'b1;
                mem_addr = w_base_q + ADDR_WIDTH'(w_cnt_q);
                w_load_d = 1'b1;
                w_row_d  = w_cnt_q;
                w_cnt_d  = w_cnt_q + RW'(1);
                if (w_cnt_q == RW'(DIM - 1)) begin
                    state_d = ST_STREAM;
                end
            end

            ST_STREAM, ST_DRAIN: begin
                // Result writes own the port ahead of activation reads.
                if (arr_r_valid && (res_cnt_q < rows_q)) begin
                    mem_en    = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = o_base_q + ADDR_WIDTH'(res_cnt_q);
                    mem_wdata = arr_r_data;
                    res_cnt_d = res_cnt_q + CNT_WIDTH'(1);
                end else if ((state_q == ST_STREAM) && (act_cnt_q < rows_q)) begin
                    mem_en    = 1'b1;
                    mem_addr  = a_base_q + ADDR_WIDTH'(act_cnt_q);
                    a_valid_d = 1'b1;
                    act_cnt_d = act_cnt_q + CNT_WIDTH'(1);
                end
                if (act_cnt_d == rows_q) begin
                    if (res_cnt_d == rows_q) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase

        if (!idle && (cycles_q != '1)) begin
            cycles_d = cycles_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state_q   <= ST_IDLE;
            w_base_q  <= '0;
            a_base_q  <= '0;
            o_base_q  <= '0;
            rows_q    <= '0;
            act_cnt_q <= '0;
            res_cnt_q <= '0;
            cycles_q  <= '0;
            w_cnt_q   <= '0;
            w_row_q   <= '0;
            w_load_q  <= 1'b0;
            a_valid_q <= 1'b0;
            rvalid_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            w_base_q  <= w_base_d;
            a_base_q  <= a_base_d;
            o_base_q  <= o_base_d;
            rows_q    <= rows_d;
            act_cnt_q <= act_cnt_d;
            res_cnt_q <= res_cnt_d;
            cycles_q  <= cycles_d;
            w_cnt_q   <= w_cnt_d;
            w_row_q   <= w_row_d;
            w_load_q  <= w_load_d;
            a_valid_q <= a_valid_d;
            rvalid_q  <= rvalid_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign sts_busy    = !idle;
    assign sts_done    = done_q;
    assign sts_err     = err_q;
    assign sts_cycles  = cycles_q;
    assign host_gnt    = idle && host_req;
    assign host_rvalid = rvalid_q;
    assign arr_w_load  = w_load_q;
    assign arr_w_row   = w_row_q;
    assign arr_a_valid = a_valid_q;

    // Read data is shared by three consumers; each sees zeros unless its strobe is up.
    assign host_rdata  = rvalid_q  ? mem_rdata : '0;
    assign arr_w_data  = w_load_q  ? mem_rdata : '0;
    assign arr_a_data  = a_valid_q ? mem_rdata : '0;

endmodule

// File: tb/tb_tpu_seq.sv
// Directed bench for tpu_seq: scratchpad and array models plus a scoreboard of
// expected weight loads, activations and result writes.
module tb_tpu_seq;

    localparam int DIM = 4;
    localparam int DW  = 32;
    localparam int AW  = 8;
    localparam int CW  = 16;
    localparam int RW  = 2;

    logic          clk = 1'b0;
    logic          rstn;
    logic          cfg_start, cfg_done_clr;
    logic [AW-1:0] cfg_w_base, cfg_a_base, cfg_o_base;
    logic [CW-1:0] cfg_rows;
    logic          sts_busy, sts_done, sts_err;
    logic [CW-1:0] sts_cycles;
    logic          host_req, host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_gnt, host_rvalid;
    logic [DW-1:0] host_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          arr_w_load, arr_a_valid, arr_r_valid;
    logic [RW-1:0] arr_w_row;
    logic [DW-1:0] arr_w_data, arr_a_data, arr_r_data;

    always #5 clk = ~clk;

    tpu_seq #(.DIM(DIM), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .s_axi_aclk(clk), .s_axi_aresetn(rstn),
        .cfg_start(cfg_start), .cfg_done_clr(cfg_done_clr),
        .cfg_w_base(cfg_w_base), .cfg_a_base(cfg_a_base), .cfg_o_base(cfg_o_base),
        .cfg_rows(cfg_rows),
        .sts_busy(sts_busy), .sts_done(sts_done), .sts_err(sts_err), .sts_cycles(sts_cycles),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .arr_w_load(arr_w_load), .arr_w_row(arr_w_row), .arr_w_data(arr_w_data),
        .arr_a_valid(arr_a_valid), .arr_a_data(arr_a_data),
        .arr_r_valid(arr_r_valid), .arr_r_data(arr_r_data)
    );

    // Scratchpad model, 1-cycle registered read.
    logic [DW-1:0] mem [0:255];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    // Array model: result = f(activation), delivered lat cycles after arr_a_valid.
    function automatic logic [DW-1:0] f_res(input logic [DW-1:0] a);
        return a * 32'd3 + 32'h11;
    endfunction

    logic [3:0]    pv = '0;
    logic [DW-1:0] pd [4];
    int            lat = 4;
    always @(posedge clk) begin
        pv    <= {pv[2:0], arr_a_valid};
        pd[0] <= f_res(arr_a_data);
        pd[1] <= pd[0];
        pd[2] <= pd[1];
        pd[3] <= pd[2];
    end
    assign arr_r_valid = pv[lat-1];
    assign arr_r_data  = pd[lat-1];

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard queues.
    logic [63:0] exp_w[$];
    logic [DW-1:0] exp_a[$];
    logic [63:0] exp_wr[$];

    task automatic push_run(input logic [AW-1:0] wb, input logic [AW-1:0] ab,
                            input logic [AW-1:0] ob, input int m);
        for (int k = 0; k < DIM; k++) exp_w.push_back({32'(k), mem[AW'(wb + AW'(k))]});
        for (int i = 0; i < m; i++) begin
            exp_a.push_back(mem[AW'(ab + AW'(i))]);
            exp_wr.push_back({32'(AW'(ob + AW'(i))), f_res(mem[AW'(ab + AW'(i))])});
        end
    endtask

    // Cycle numbering relative to the edge that accepted cfg_start.
    int edge_n = 0, start_edge = 0, cyc;
    always @(posedge clk) begin
        edge_n <= edge_n + 1;
        if (cfg_start && !sts_busy && rstn) start_edge <= edge_n + 1;
    end

    int a_idx = 0, last_wr_cyc = 0, mem_en_cnt = 0, gnt_busy_cnt = 0, abort_wr_cnt = 0;
    bit no_wr_window = 1'b0;
    logic [63:0] e;
    always @(negedge clk) begin
        cyc = edge_n - start_edge + 1;
        if (mem_en === 1'b1) mem_en_cnt++;
        if (sts_busy && host_gnt) gnt_busy_cnt++;
        if (no_wr_window && mem_en && mem_we) abort_wr_cnt++;
        if (arr_w_load === 1'b1) begin
            if (exp_w.size() == 0) check("w_unexpected", 1, 0);
            else begin
                e = exp_w.pop_front();
                check("w_row", 64'(arr_w_row), e[63:32]);
                check("w_data", 64'(arr_w_data), 64'(e[31:0]));
                check("w_cycle", 64'(cyc), 64'(2 + e[63:32]));
            end
        end
        if (arr_a_valid === 1'b1) begin
            if (exp_a.size() == 0) check("a_unexpected", 1, 0);
            else begin
                check("a_data", 64'(arr_a_data), 64'(exp_a.pop_front()));
                if (a_idx == 0) check("a_first_cycle", 64'(cyc), 64'(DIM + 2));
                a_idx++;
            end
        end
        if (mem_en === 1'b1 && mem_we === 1'b1 && sts_busy === 1'b1) begin
            if (exp_wr.size() == 0) check("wr_unexpected", 1, 0);
            else begin
                e = exp_wr.pop_front();
                check("wr_addr", 64'(mem_addr), 64'(e[63:32]));
                check("wr_data", 64'(mem_wdata), 64'(e[31:0]));
            end
            last_wr_cyc = cyc;
        end
    end

    task automatic start_run(input logic [AW-1:0] wb, input logic [AW-1:0] ab,
                             input logic [AW-1:0] ob, input logic [CW-1:0] m);
        @(negedge clk);
        cfg_w_base = wb; cfg_a_base = ab; cfg_o_base = ob; cfg_rows = m;
        cfg_start  = 1'b1;
        @(negedge clk);
        cfg_start  = 1'b0;
    endtask

    task automatic wait_done(input int max, input string tag);
        int n = 0;
        while (sts_busy === 1'b1 && n < max) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_timeout"}, 64'(n < max), 1);
    endtask

    task automatic check_empty(input string tag);
        check({tag, "_w_left"}, 64'(exp_w.size()), 0);
        check({tag, "_a_left"}, 64'(exp_a.size()), 0);
        check({tag, "_wr_left"}, 64'(exp_wr.size()), 0);
    endtask

    logic [DW-1:0] hval;

    initial begin
        rstn = 1'b0; cfg_start = 0; cfg_done_clr = 0;
        cfg_w_base = 0; cfg_a_base = 0; cfg_o_base = 0; cfg_rows = 0;
        host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(sts_busy), 0);
        check("rst_done", 64'(sts_done), 0);
        check("rst_err", 64'(sts_err), 0);
        check("rst_cycles", 64'(sts_cycles), 0);
        check("rst_mem_en", 64'(mem_en), 0);
        check("rst_w_load", 64'(arr_w_load), 0);
        check("rst_a_valid", 64'(arr_a_valid), 0);
        check("rst_rvalid", 64'(host_rvalid), 0);
        rstn = 1'b1;

        // Host write then read of 0x20 while idle.
        @(negedge clk);
        hval = 32'hCAFE_0020;
        host_req = 1; host_we = 1; host_addr = 8'h20; host_wdata = hval;
        #1 check("host_wr_gnt", 64'(host_gnt), 1);
        @(negedge clk);
        host_we = 0;
        #1 check("host_rd_gnt", 64'(host_gnt), 1);
        @(negedge clk);
        host_req = 0;
        check("host_rvalid", 64'(host_rvalid), 1);
        check("host_rdata", 64'(host_rdata), 64'(hval));
        @(negedge clk);
        check("host_rvalid_pulse", 64'(host_rvalid), 0);

        // Run 1: M=3, latency 4, host read pending and done_clr on the done cycle.
        lat = 4; a_idx = 0; gnt_busy_cnt = 0;
        push_run(8'h00, 8'h10, 8'h40, 3);
        start_run(8'h00, 8'h10, 8'h40, 16'd3);
        check("run1_busy", 64'(sts_busy), 1);
        host_req = 1; host_we = 0; host_addr = 8'h20;
        #1 check("run1_gnt_busy", 64'(host_gnt), 0);
        repeat (11) @(negedge clk);
        cfg_done_clr = 1;
        @(negedge clk);
        cfg_done_clr = 0;
        check("run1_done_set_wins", 64'(sts_done), 1);
        check("run1_busy_clear", 64'(sts_busy), 0);
        check("run1_cycles", 64'(sts_cycles), 12);
        check("run1_last_wr", 64'(last_wr_cyc), 12);
        check("run1_gnt_after", 64'(host_gnt), 1);
        check("run1_gnt_during", 64'(gnt_busy_cnt), 0);
        check_empty("run1");
        @(negedge clk);
        host_req = 0;
        check("run1_host_rvalid", 64'(host_rvalid), 1);
        check("run1_host_rdata", 64'(host_rdata), 64'(hval));
        for (int i = 0; i < 3; i++)
            check("run1_mem_image", 64'(mem[8'h40 + i]), 64'(f_res(mem[8'h10 + i])));

        // Rejected runs: zero rows, then activation range past the top.
        mem_en_cnt = 0;
        start_run(8'h00, 8'h10, 8'h40, 16'd0);
        check("err_rows0", 64'(sts_err), 1);
        check("err_rows0_busy", 64'(sts_busy), 0);
        check("err_done_cleared", 64'(sts_done), 0);
        repeat (2) @(negedge clk);
        check("err_sticky", 64'(sts_err), 1);
        cfg_done_clr = 1;
        @(negedge clk);
        cfg_done_clr = 0;
        check("err_clr", 64'(sts_err), 0);
        start_run(8'h00, 8'hFE, 8'h40, 16'd4);
        check("err_abase", 64'(sts_err), 1);
        check("err_abase_busy", 64'(sts_busy), 0);
        @(negedge clk);
        check("err_no_mem_en", 64'(mem_en_cnt), 0);

        // Run 2: latency 2 forces result writes to preempt activation reads.
        lat = 2; a_idx = 0;
        push_run(8'h00, 8'h80, 8'hC0, 8);
        start_run(8'h00, 8'h80, 8'hC0, 16'd8);
        check("run2_err_cleared", 64'(sts_err), 0);
        repeat (6) @(negedge clk);
        cfg_w_base = 8'h30; cfg_a_base = 8'h00; cfg_o_base = 8'h00; cfg_rows = 16'd1;
        cfg_start = 1;
        @(negedge clk);
        cfg_start = 0;
        check("run2_start_ignored", 64'(sts_busy), 1);
        wait_done(100, "run2");
        check("run2_done", 64'(sts_done), 1);
        check("run2_cycles", 64'(sts_cycles), 21);
        check("run2_last_wr", 64'(last_wr_cyc), 21);
        check_empty("run2");
        for (int i = 0; i < 8; i++)
            check("run2_mem_image", 64'(mem[8'hC0 + i]), 64'(f_res(mem[8'h80 + i])));

        // Run 3: reset during STREAM; in-flight results must not be written.
        lat = 4; a_idx = 0; abort_wr_cnt = 0;
        push_run(8'h00, 8'h10, 8'h50, 3);
        start_run(8'h00, 8'h10, 8'h50, 16'd3);
        repeat (6) @(negedge clk);
        #2 rstn = 1'b0;
        exp_w.delete(); exp_a.delete(); exp_wr.delete();
        no_wr_window = 1'b1;
        #1;
        check("abort_busy", 64'(sts_busy), 0);
        check("abort_mem_en", 64'(mem_en), 0);
        check("abort_mem_we", 64'(mem_we), 0);
        check("abort_a_valid", 64'(arr_a_valid), 0);
        check("abort_w_load", 64'(arr_w_load), 0);
        check("abort_cycles", 64'(sts_cycles), 0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (8) @(negedge clk);
        no_wr_window = 1'b0;
        check("abort_no_writes", 64'(abort_wr_cnt), 0);

        // Run 4: weights at the very top of the address space.
        a_idx = 0;
        push_run(8'hFC, 8'h10, 8'h40, 3);
        start_run(8'hFC, 8'h10, 8'h40, 16'd3);
        check("run4_accepted", 64'(sts_busy), 1);
        wait_done(100, "run4");
        check("run4_done", 64'(sts_done), 1);
        check("run4_err", 64'(sts_err), 0);
        check("run4_cycles", 64'(sts_cycles), 12);
        check_empty("run4");

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tpu_seq.md
# tpu_seq

Sequencer and scratchpad arbiter for the TPU datapath. It starts when the AXI-Lite register map delivers a start pulse, then runs three phases against the single-port scratchpad: load DIM weight rows into the systolic array, stream M activation rows, and write M result words back. While idle it hands the scratchpad port to the host access path. It reports busy, done, error and cycle-count status back to the register map.

## Interface
Parameters:
- DIM, 4: array dimension; weight rows loaded per run.
- DATA_WIDTH, 32: scratchpad word width (DIM packed 8-bit elements).
- ADDR_WIDTH, 8: scratchpad word-address width.
- CNT_WIDTH, 16: width of the row count and the cycle counter.

Ports:
- s_axi_aclk, in, 1: clock.
- s_axi_aresetn, in, 1: reset, asynchronous, active-low.
- cfg_start, in, 1: single-cycle start pulse.
- cfg_done_clr, in, 1: clears sts_done and sts_err.
- cfg_w_base / cfg_a_base / cfg_o_base, in, ADDR_WIDTH each: weight, activation and output base addresses.
- cfg_rows, in, CNT_WIDTH: M, the number of activation rows.
- sts_busy / sts_done / sts_err, out, 1 each: run status.
- sts_cycles, out, CNT_WIDTH: busy cycles of the last run.
- host_req / host_we, in, 1 each: host scratchpad access request and write enable.
- host_addr, in, ADDR_WIDTH: host access address.
- host_wdata, in, DATA_WIDTH: host write data.
- host_gnt, out, 1: combinational grant.
- host_rdata, out, DATA_WIDTH: host read data.
- host_rvalid, out, 1: host read data valid.
- mem_en / mem_we, out, 1 each: scratchpad enable and write enable.
- mem_addr, out, ADDR_WIDTH: scratchpad address.
- mem_wdata, out, DATA_WIDTH: scratchpad write data.
- mem_rdata, in, DATA_WIDTH: scratchpad read data, 1-cycle read latency.
- arr_w_load, out, 1: weight row load strobe.
- arr_w_row, out, log2(DIM): weight row index.
- arr_w_data, out, DATA_WIDTH: weight row data.
- arr_a_valid, out, 1: activation row valid.
- arr_a_data, out, DATA_WIDTH: activation row data.
- arr_r_valid, in, 1: result word valid.
- arr_r_data, in, DATA_WIDTH: result word.

## Operation
- States: IDLE, LOAD_W, STREAM, DRAIN.
- Reset values: all status outputs, counters, mem_*, arr_* strobes and host_rvalid are 0; the state is IDLE.

IDLE
- host_gnt = host_req. The host drives mem_* directly.
- host_rvalid pulses 1 cycle after a granted read, with host_rdata = mem_rdata.
- On cfg_start, cfg_rows and the bases are latched. sts_done, sts_err and sts_cycles are cleared.
- Error check: the run is rejected if cfg_rows == 0, or if either of the following exceeds 2^ADDR_WIDTH:
  - cfg_a_base + cfg_rows
  - cfg_o_base + cfg_rows
  - cfg_w_base + DIM
- On rejection, sts_err is set and the state stays IDLE. Otherwise the state goes to LOAD_W.

LOAD_W
- Issues reads at w_base + k for k = 0..DIM-1, one per cycle.
- One cycle after each read: arr_w_load = 1, arr_w_row = k, arr_w_data = mem_rdata.
- After the last read is issued, the state goes to STREAM.

STREAM
- Each cycle the scratchpad port has one owner, in this priority:
  1. If arr_r_valid: write arr_r_data to o_base + res_cnt, then increment res_cnt.
  2. Otherwise, if act_cnt < M: read a_base + act_cnt, then increment act_cnt.
- One cycle after each activation read: arr_a_valid = 1, arr_a_data = mem_rdata.
- When act_cnt == M, the state goes to DRAIN.

DRAIN
- Writes results as in STREAM.
- When the final write happens (res_cnt reaches M), the next state is IDLE, sts_done is set and sts_busy is cleared.

Status and boundary rules
- sts_busy = 1 in every state except IDLE.
- host_gnt = 0 while busy. Host requests stall; they are not dropped.
- sts_cycles increments every busy cycle and saturates at all-ones.
- cfg_start while busy is ignored.
- arr_r_valid in IDLE or LOAD_W is ignored and causes no write.
- sts_done and sts_err are sticky. They clear on cfg_done_clr or on an accepted cfg_start. If a set and a clear occur in the same cycle, the set wins.
- Reset mid-run aborts immediately. No further scratchpad writes occur, and all outputs return to their reset values.

## Timing
- cfg_start sampled at edge 0.
- LOAD_W occupies cycles 1..DIM (reads). arr_w_load is high on cycles 2..DIM+1.
- STREAM begins at cycle DIM+1. With no result interference, arr_a_valid is high on cycles DIM+2..DIM+M+1.
- The activation read stream stalls 1 cycle per result write.
- The final write occurs in cycle T. sts_done = 1 and sts_busy = 0 from cycle T+1.
- sts_cycles = T (cycles 1..T inclusive).
- host_gnt is combinational from the state. Host accesses cost 1 cycle, plus 1 cycle of read latency.

## Test plan
- DIM=4, w_base=0x00, a_base=0x10, o_base=0x40, M=3, array model returns a result 4 cycles after each activation -> arr_w_load cycles 2..5 with rows 0..3 and the preloaded weights; 3 activations; results written at 0x40..0x42; sts_done=1; sts_cycles matches the model.
- Results arrive on consecutive cycles while activations remain -> writes win, activation reads stall, no activation is skipped or duplicated; final memory image is correct.
- cfg_rows=0, and separately a_base=0xFE with M=4 -> sts_err=1, sts_busy stays 0, no mem_en.
- Host read and write of 0x20 in IDLE -> granted; host_rvalid 1 cycle later with correct data. Host request during a run -> host_gnt=0 until the cycle after done, then granted.
- cfg_start pulsed mid-run -> ignored, latched config unchanged. cfg_done_clr in the same cycle as done set -> sts_done=1.
- Reset asserted during STREAM -> all outputs 0, state IDLE, no further writes. A new start after release completes normally.
